// File: rtl/demux_deser_pkg.sv
// Shared definitions for the serial-to-parallel demux receiver.
package demux_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned SEL_W_DEF = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [WIDTH_DEF-1:0] onehot(input logic [SEL_W_DEF-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_deser_if.sv
// Handshake bundle between the serial source, the receiver and the word consumer.
interface demux_deser_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) ();

  logic             in_bit;
  logic [SEL_W-1:0] in_sel;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] fill_mask;
  logic             dup_err;

  modport master (
    output in_bit, in_sel, in_valid, clear, out_ready,
    input  in_ready, out_data, out_valid, fill_mask, dup_err
  );

  modport slave (
    input  in_bit, in_sel, in_valid, clear, out_ready,
    output in_ready, out_data, out_valid, fill_mask, dup_err
  );

endinterface

// File: rtl/demux_deser_1to16.sv
// Select-to-one-hot decoder with enable; inverse of the mux_b position select.
module demux_1to16
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_onehot[i] = i_en && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux_deser.sv
// Rebuilds a WIDTH-bit word from position-tagged serial bits; hands it off via valid/ready.
module demux_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_deser_if.slave  bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_mask;
  logic             r_dup;

  logic             w_accept;
  logic [WIDTH-1:0] w_onehot;
  logic [WIDTH-1:0] w_data_next;
  logic [WIDTH-1:0] w_mask_next;
  logic             w_dup;
  logic             w_complete;

  // clear suppresses the write strobe so the concurrent bit never lands
  assign w_accept = bus.in_valid && (r_state == FILL) && !bus.clear;

  demux_1to16 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel    (bus.in_sel),
    .i_en     (w_accept),
    .o_onehot (w_onehot)
  );

  assign w_data_next = (r_data & ~w_onehot) | (bus.in_bit ? w_onehot : '0);
  assign w_mask_next = r_mask | w_onehot;
  assign w_dup       = |(r_mask & w_onehot);
  assign w_complete  = w_accept && (&w_mask_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_data     <= '0;
      r_out_data <= '0;
      r_mask     <= '0;
      r_dup      <= 1'b0;
    end else begin
      r_dup <= 1'b0;
      if (bus.clear) begin
        r_state <= FILL;
        r_mask  <= '0;
      end else begin
        case (r_state)
          FILL: begin
            if (w_accept) begin
              r_data <= w_data_next;
              r_mask <= w_mask_next;
              r_dup  <= w_dup;
              if (w_complete) begin
                r_state    <= HOLD;
                r_out_data <= w_data_next;
              end
            end
          end
          HOLD: begin
            if (bus.out_ready) begin
              r_state <= FILL;
              r_mask  <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == FILL);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_out_data;
  assign bus.fill_mask = r_mask;
  assign bus.dup_err   = r_dup;

endmodule

// File: tb/tb_demux_deser.sv
// Directed self-checking bench for demux_deser.
module tb_demux_deser;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  demux_deser_if #(.WIDTH(16), .SEL_W(4)) bus ();

  demux_deser #(.WIDTH(16), .SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic b, input logic [3:0] s);
    bus.in_bit   = b;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [3:0]  seq2 [13];

    bus.in_bit    = 1'b0;
    bus.in_sel    = '0;
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_fill_mask", 32'(bus.fill_mask), 32'd0);
    chk("rst_dup_err",   32'(bus.dup_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Sequential fill with 16'hA5C3
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      wr(pat[i], 4'(i));
      if (i == 14) begin
        chk("seq_mask_14",  32'(bus.fill_mask), 32'h7FFF);
        chk("seq_valid_14", 32'(bus.out_valid), 32'd0);
      end
    end
    chk("seq_out_valid", 32'(bus.out_valid), 32'd1);
    chk("seq_out_data",  32'(bus.out_data),  32'hA5C3);
    chk("seq_in_ready",  32'(bus.in_ready),  32'd0);
    chk("seq_mask_full", 32'(bus.fill_mask), 32'hFFFF);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("seq_rel_valid", 32'(bus.out_valid), 32'd0);
    chk("seq_rel_mask",  32'(bus.fill_mask), 32'd0);
    chk("seq_rel_ready", 32'(bus.in_ready),  32'd1);

    // Partial, out-of-order fill
    seq2 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'hE, 4'hD, 4'hC};
    for (int i = 0; i < 13; i++) wr(1'b1, seq2[i]);
    chk("ooo_mask",  32'(bus.fill_mask), 32'hF1FF);
    chk("ooo_valid", 32'(bus.out_valid), 32'd0);
    wr(1'b0, 4'h9);
    wr(1'b0, 4'hA);
    wr(1'b0, 4'hB);
    chk("ooo_done_valid", 32'(bus.out_valid), 32'd1);
    chk("ooo_done_data",  32'(bus.out_data),  32'hF1FF);

    // Backpressure: hold word with in_valid pulses ignored
    for (int i = 0; i < 5; i++) begin
      wr(i[0], 4'(i));
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data",  32'(bus.out_data),  32'hF1FF);
      chk("bp_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_dup",   32'(bus.dup_err),   32'd0);
    end
    chk("bp_mask", 32'(bus.fill_mask), 32'hFFFF);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("bp_rel_valid", 32'(bus.out_valid), 32'd0);

    // Duplicate select
    wr(1'b1, 4'h3);
    chk("dup_first_err",  32'(bus.dup_err),   32'd0);
    chk("dup_first_mask", 32'(bus.fill_mask), 32'h0008);
    wr(1'b0, 4'h3);
    chk("dup_second_err",  32'(bus.dup_err),   32'd1);
    chk("dup_second_mask", 32'(bus.fill_mask), 32'h0008);
    cyc();
    chk("dup_pulse_end", 32'(bus.dup_err), 32'd0);
    for (int i = 0; i < 16; i++) if (i != 3) wr(1'b1, 4'(i));
    chk("dup_word_valid", 32'(bus.out_valid), 32'd1);
    chk("dup_word_data",  32'(bus.out_data),  32'hFFF7);
    chk("dup_word_err",   32'(bus.dup_err),   32'd0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Clear during fill drops partial word and concurrent bit
    for (int i = 0; i < 10; i++) wr(1'b1, 4'(i));
    chk("clr_pre_mask", 32'(bus.fill_mask), 32'h03FF);
    bus.clear = 1'b1;
    wr(1'b1, 4'hA);
    bus.clear = 1'b0;
    chk("clr_mask",  32'(bus.fill_mask), 32'd0);
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_dup",   32'(bus.dup_err),   32'd0);
    chk("clr_ready", 32'(bus.in_ready),  32'd1);

    // Clear in HOLD
    for (int i = 0; i < 16; i++) wr(i[0], 4'(i));
    chk("clrh_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("clrh_pre_data",  32'(bus.out_data),  32'hAAAA);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clrh_valid", 32'(bus.out_valid), 32'd0);
    chk("clrh_mask",  32'(bus.fill_mask), 32'd0);
    chk("clrh_ready", 32'(bus.in_ready),  32'd1);

    // Async reset mid-word, between edges
    for (int i = 0; i < 8; i++) wr(1'b1, 4'(i));
    chk("ar_pre_mask", 32'(bus.fill_mask), 32'h00FF);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mask",  32'(bus.fill_mask), 32'd0);
    chk("ar_data",  32'(bus.out_data),  32'd0);
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_ready", 32'(bus.in_ready),  32'd1);
    chk("ar_dup",   32'(bus.dup_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 8; i < 16; i++) wr(1'b1, 4'(i));
    chk("ar_half_mask",  32'(bus.fill_mask), 32'hFF00);
    chk("ar_half_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) wr(1'b0, 4'(i));
    chk("ar_full_valid", 32'(bus.out_valid), 32'd1);
    chk("ar_full_data",  32'(bus.out_data),  32'hFF00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_deser.md
Name: demux_deser

Overview:
- Receiving end of the 16:1 mux serial path: takes one bit per clock, tagged with its 4-bit position select.
- Demultiplexes each bit into the addressed position of a WIDTH-bit word and tracks which positions are filled.
- Presents the completed word on a valid/ready output handshake.
- Sits downstream of any mux_b-driven serializer and rebuilds the parallel word that the mux walked through.

Parameters:
- WIDTH, 16, word width and number of select positions.
- SEL_W, 4, select width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_bit  input  1  serial data bit
- in_sel  input  SEL_W  destination bit position of in_bit
- in_valid  input  1  in_bit/in_sel valid this cycle
- in_ready  output  1  block accepts input this cycle
- clear  input  1  synchronous abort; discards the partial word
- out_data  output  WIDTH  assembled word
- out_valid  output  1  out_data complete and stable
- out_ready  input  1  consumer accepts out_data
- fill_mask  output  WIDTH  bit i set = position i written in the current word
- dup_err  output  1  one-cycle pulse: accepted write hit an already-filled position

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FILL.
  - out_data = 0, fill_mask = 0, out_valid = 0, dup_err = 0.
  - in_ready = 1 after reset release.
- Accept condition: in_valid & in_ready, sampled on the rising edge.
- FSM states:
  - FILL: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- FILL, on accept:
  - Set data_reg[in_sel] = in_bit and fill_mask[in_sel] = 1.
  - Other bits of data_reg and fill_mask are unchanged.
- Duplicate select in FILL:
  - data_reg[in_sel] is overwritten with the new bit; the mask is unchanged.
  - dup_err pulses high for exactly the cycle after the edge.
- Word completion:
  - Condition: (fill_mask | onehot(in_sel)) == all ones at an accept edge.
  - At that edge: next state = HOLD, and out_data loads the merged word including the current bit.
  - out_valid is high from the following cycle; latency is 1 cycle from the final accept.
- HOLD:
  - out_data and fill_mask are held stable.
  - in_valid is ignored; no write and no dup_err.
- HOLD, on out_ready (sampled at the edge): next state = FILL, fill_mask = 0.
  - out_data keeps its last value; it is only meaningful while out_valid = 1.
- out_ready in FILL has no effect.
- clear has priority over everything except reset:
  - Next state = FILL, fill_mask = 0, and the bit presented that cycle is discarded (no write).
  - A pending HOLD word is dropped; out_valid falls the next cycle.
  - dup_err = 0.
- Out-of-order selects are legal. Completion depends only on every position being written at least once, not on order.
- No bypass: a word cannot complete and be consumed in the same cycle. Minimum throughput is WIDTH+1 cycles per word.
- Reset mid-fill: all partial state is lost and no out_valid is produced.

Decomposition:
- Shared package demux_pkg:
  - WIDTH_DEF = 16 and SEL_W_DEF = 4.
  - FSM state encoding: FILL = 1'b0, HOLD = 1'b1.
  - onehot decode function.
- One natural sub-module, demux_1to16: combinational decode of in_sel plus a write-enable into a one-hot WIDTH vector. It serves as the literal inverse of mux_b and is reused for both the data write and the mask update.

Test Plan:
- Sequential fill: after reset, present sel = 0..15 with in_bit = bit i of 16'hA5C3, in_valid held high.
  - Required: out_valid rises the cycle after sel = 15, out_data = 16'hA5C3, in_ready = 0.
  - With out_ready = 1, the block returns to FILL and fill_mask = 0.
- Partial/out-of-order: present sel 0,1,2,3,4,5,6,7,8,f,e,d,c (13 writes, all in_bit = 1).
  - Required: fill_mask = 16'hF1FF and out_valid stays 0.
  - Then write sel 9,a,b with in_bit = 0: out_valid = 1, out_data = 16'hF1FF.
- Backpressure: complete a word with out_ready = 0 for 5 cycles.
  - Required: out_valid stays 1, out_data stays stable, in_ready stays 0, and in_valid pulses are ignored.
  - On out_ready = 1: out_valid = 0 the next cycle.
- Duplicate: write sel = 3 with bit 1, then sel = 3 with bit 0.
  - Required: dup_err is a single-cycle pulse after the second write, fill_mask = 16'h0008, and data bit 3 = 0 in the final word.
- Clear: fill 10 positions, then assert clear together with in_valid.
  - Required: fill_mask = 0 the next cycle and the concurrent bit is dropped.
  - A clear asserted in HOLD drops out_valid the next cycle.
- Async reset: assert rst_n = 0 mid-word, between clock edges.
  - Required: outputs go to their reset values immediately, and no out_valid appears after release until 16 new positions are written.
